// File: rtl/uart_rx.sv
// 8N1 serial receiver for the program loader: mid-bit sampling, one-byte holding register,
// valid/enable handshake, framing and overrun error pulses, active-low rts.
module uart_rx #(
  parameter int unsigned CLOCK_COUNT_MAX = 1302
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       rts,
  output logic [7:0] read_data,
  output logic       read_data_valid,
  input  logic       read_data_enable,
  output logic       framing_error,
  output logic       overrun_error
);

  localparam int unsigned HALF_COUNT = CLOCK_COUNT_MAX / 2;
  localparam logic [15:0] CountMax   = 16'(CLOCK_COUNT_MAX);
  localparam logic [15:0] CountHalf  = 16'(HALF_COUNT);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
  localparam logic [2:0] StBreak = 3'd4;

  logic        sync1_q, sync2_q;
  logic [2:0]  state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        rts_q;
  logic        ferr_q, ferr_d;
  logic        oerr_q, oerr_d;
  logic        deliver;
  logic        rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ferr_d    = 1'b0;
    deliver   = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d   = StStart;
          clk_cnt_d = 16'd1;
        end
      end
      StStart: begin
        if (clk_cnt_q == CountHalf) begin
          // Line back high at mid start bit: treat as a glitch and resume idle.
          if (!rx_s) begin
            state_d   = StData;
            clk_cnt_d = 16'd1;
            bit_cnt_d = 4'd0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      StData: begin
        if (clk_cnt_q == CountMax) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          clk_cnt_d = 16'd1;
          if (bit_cnt_q == 4'd7) begin
            state_d = StStop;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (clk_cnt_q == CountMax) begin
          if (rx_s) begin
            deliver = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      StBreak: begin
        // Hold off until the line returns high so a held-low line cannot retrigger.
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    oerr_d  = 1'b0;
    if (deliver) begin
      if (!valid_q) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else if (read_data_enable) begin
        data_d = shift_q;
      end else begin
        oerr_d = 1'b1;
      end
    end else if (valid_q && read_data_enable) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= StIdle;
      clk_cnt_q <= 16'd0;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      rts_q     <= 1'b0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      rts_q     <= valid_d;
      ferr_q    <= ferr_d;
      oerr_q    <= oerr_d;
    end
  end

  assign rts             = rts_q;
  assign read_data       = data_q;
  assign read_data_valid = valid_q;
  assign framing_error   = ferr_q;
  assign overrun_error   = oerr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against a byte-level model of the receiver's holding register.
module tb_uart_rx;

  localparam int unsigned Cmax = 16;
  // Stop-bit sample edge after rx falls, and the cycle where valid rises.
  localparam int SampleEdge = 2 + Cmax / 2 + 9 * Cmax;
  localparam int Latency    = SampleEdge + 1;
  localparam int RdCyc      = SampleEdge - 1;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic       rts;
  logic [7:0] read_data;
  logic       read_data_valid;
  logic       read_data_enable;
  logic       framing_error;
  logic       overrun_error;

  int total = 0;
  int bad = 0;
  int cyc_now = 0;
  int rise_cyc = 0;
  int ferr_cnt = 0;
  int oerr_cnt = 0;
  logic valid_prev = 1'b0;

  // Reference model state
  logic       mv;
  logic [7:0] md;
  int         exp_ferr = 0;
  int         exp_oerr = 0;

  uart_rx #(.CLOCK_COUNT_MAX(Cmax)) dut (
    .clock           (clock),
    .reset           (reset),
    .rx              (rx),
    .rts             (rts),
    .read_data       (read_data),
    .read_data_valid (read_data_valid),
    .read_data_enable(read_data_enable),
    .framing_error   (framing_error),
    .overrun_error   (overrun_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc_now <= cyc_now + 1;

  always @(negedge clock) begin
    if (framing_error) ferr_cnt <= ferr_cnt + 1;
    if (overrun_error) oerr_cnt <= oerr_cnt + 1;
    if (read_data_valid && !valid_prev) rise_cyc <= cyc_now;
    valid_prev <= read_data_valid;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "/valid"}, 32'(read_data_valid), 32'(mv));
    check({tag, "/rts"}, 32'(rts), 32'(mv));
    check({tag, "/data"}, 32'(read_data), 32'(md));
    check({tag, "/ferr"}, ferr_cnt, exp_ferr);
    check({tag, "/oerr"}, oerr_cnt, exp_oerr);
  endtask

  // Drives one 8N1 frame; rd_cyc selects the frame cycle (if any) where enable is high.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rd_cyc);
    logic [9:0] bits;
    int start_cyc;
    logic pre_valid;
    int c;
    bits      = {stop, b, 1'b0};
    start_cyc = cyc_now;
    pre_valid = mv;
    c         = 0;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      for (int k = 0; k < int'(Cmax); k++) begin
        read_data_enable = (c == rd_cyc);
        tick();
        c++;
      end
    end
    read_data_enable = 1'b0;
    if (stop) begin
      if (!mv) begin
        mv = 1'b1;
        md = b;
      end else if (rd_cyc == RdCyc) begin
        md = b;
      end else begin
        exp_oerr++;
      end
      if (!pre_valid) check("latency", rise_cyc - start_cyc, Latency);
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic read_pulse();
    read_data_enable = 1'b1;
    tick();
    read_data_enable = 1'b0;
    mv = 1'b0;
  endtask

  initial begin
    logic [9:0] pbits;
    logic [7:0] rb;
    int mode;
    reset            = 1'b1;
    rx               = 1'b1;
    read_data_enable = 1'b0;
    mv               = 1'b0;
    md               = 8'h00;
    repeat (3) tick();
    check("reset/rts", 32'(rts), 0);
    check("reset/data", 32'(read_data), 0);
    check("reset/valid", 32'(read_data_valid), 0);
    check("reset/ferr", 32'(framing_error), 0);
    check("reset/oerr", 32'(overrun_error), 0);
    reset = 1'b0;
    repeat (5) tick();

    // Single byte, then consume it
    send_frame(8'hA5, 1'b1, -1);
    check_state("single");
    read_pulse();
    check_state("single_read");

    // Short low glitch is rejected
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    repeat (30) tick();
    check_state("glitch");
    send_frame(8'h3C, 1'b1, -1);
    check_state("after_glitch");
    read_pulse();

    // Framing error followed by a held-low line
    send_frame(8'h55, 1'b0, -1);
    repeat (40) tick();
    rx = 1'b1;
    repeat (4) tick();
    check_state("framing");
    send_frame(8'h81, 1'b1, -1);
    check_state("after_framing");
    read_pulse();

    // Overrun on back-to-back frames
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    check_state("overrun");

    // Read in the exact deliver cycle replaces the byte without overrun
    send_frame(8'h22, 1'b1, RdCyc);
    check_state("simul");

    // Reset during data bit 4 of 0xF0 with a byte still held
    pbits = {1'b1, 8'hF0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = pbits[i];
      repeat (Cmax) tick();
    end
    rx = pbits[5];
    repeat (Cmax / 2) tick();
    reset = 1'b1;
    tick();
    check("midreset/rts", 32'(rts), 0);
    check("midreset/data", 32'(read_data), 0);
    check("midreset/valid", 32'(read_data_valid), 0);
    check("midreset/ferr", 32'(framing_error), 0);
    check("midreset/oerr", 32'(overrun_error), 0);
    reset = 1'b0;
    rx    = 1'b1;
    mv    = 1'b0;
    md    = 8'h00;
    repeat (20) tick();
    send_frame(8'h0F, 1'b1, -1);
    check_state("after_reset");

    // Random bytes with random consumer behaviour
    for (int n = 0; n < 10; n++) begin
      rb   = 8'($urandom);
      mode = int'($urandom_range(0, 2));
      send_frame(rb, 1'b1, (mode == 1) ? RdCyc : -1);
      if (mode == 2) read_pulse();
      check_state("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive side of the 8N1 serial link used for the program loader.
- Samples the asynchronous `rx` pin at mid-bit using a clock-tick counter.
- Reassembles LSB-first data bytes into a one-byte holding register.
- Presents each byte to the downstream consumer through a valid/enable handshake, and reports framing and overrun errors.
- Drives `rts` (active-low ready) for the remote transmitter's `cts`, matching the active-low `cts` convention of the transmit side.

Parameters:
- CLOCK_COUNT_MAX, 1302 (12500000 / 9600): clock ticks per bit period. Legal range 4..65535. HALF_COUNT = CLOCK_COUNT_MAX / 2, truncated.

Ports:
- clock  input  1  12.5 MHz system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial input; idles high.
- rts  output  1  0 = ready for a byte (holding register empty); 1 = holding register full.
- read_data  output  8  received byte; meaningful only while read_data_valid = 1.
- read_data_valid  output  1  holding register contains an unread byte.
- read_data_enable  input  1  consumer takes the byte; honoured only while read_data_valid = 1.
- framing_error  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun_error  output  1  one-cycle pulse: byte completed while holding register full and not being read.

Behaviour:
- Reset values:
  - Outputs: rts = 0, read_data = 0, read_data_valid = 0, framing_error = 0, overrun_error = 0.
  - Internal: both synchronizer flops = 1, state = IDLE, counters = 0.
- Reset asserted mid-frame aborts the frame; the partial byte is discarded.
- Synchronizer: rx passes through two flops; rx_s = second flop. All FSM decisions use rx_s only.
- Clock counter: 16-bit. Bit counter: 4-bit. Shift register: 8 bits, filled LSB first (new bit enters bit 7, register shifts right).
- FSM states:
  - IDLE: rx_s = 0 -> START, clock_counter = 1. Otherwise stay.
  - START: increment counter. At counter == HALF_COUNT:
    - rx_s = 0 -> DATA, counter = 1, bit_counter = 0.
    - rx_s = 1 -> IDLE (glitch rejected, no error).
  - DATA: at counter == CLOCK_COUNT_MAX:
    - Shift rx_s in, bit_counter + 1, counter = 1.
    - After the 8th bit (bit_counter was 7) -> STOP.
    - Otherwise increment counter.
  - STOP: at counter == CLOCK_COUNT_MAX, sample rx_s:
    - rx_s = 1 -> deliver the byte (see holding register), then IDLE.
    - rx_s = 0 -> framing_error = 1 for exactly one cycle, byte discarded -> BREAK.
  - BREAK: wait for rx_s = 1, then IDLE. This prevents a held-low line from retriggering a start.
- Holding register (evaluated in the same cycle as the stop-bit sample = "deliver"):
  - Deliver, valid = 0: read_data = shift register, read_data_valid = 1 next cycle.
  - Deliver, valid = 1, read_data_enable = 1: new byte replaces old; valid stays 1; no error.
  - Deliver, valid = 1, read_data_enable = 0: new byte dropped, old byte kept, overrun_error pulses one cycle.
  - No deliver, valid = 1, read_data_enable = 1: valid = 0 next cycle; read_data holds its last value.
  - read_data_enable while valid = 0: ignored.
- rts is registered and equals read_data_valid (same cycle values).
- Latency: read_data_valid rises 1 cycle after the stop-bit sample. That sample is 2 (sync) + HALF_COUNT + 8·CLOCK_COUNT_MAX + CLOCK_COUNT_MAX cycles after rx falls, within ±1 cycle.
- A new falling edge is accepted in the first IDLE cycle after STOP. Back-to-back frames with a 1-bit stop must be received without loss.

Test Plan:
- Use CLOCK_COUNT_MAX = 16 for all scenarios.
- Single byte: drive 0xA5 as 8N1 at 16 cycles/bit, read_data_enable held 0 -> read_data_valid = 1, read_data = 0xA5, rts = 1, no error pulses; then pulse read_data_enable 1 cycle -> valid = 0 and rts = 0 next cycle.
- Glitch rejection: rx low for 5 cycles, then high -> FSM returns to IDLE; no valid, no framing_error; a following 0x3C frame is received correctly.
- Framing error: frame 0x55 with stop bit = 0, then line held low 40 cycles, then high -> framing_error pulses exactly once; valid stays 0; no spurious start during the low period; next 0x81 frame is received.
- Overrun: send 0x11 then 0x22 back-to-back, never reading -> overrun_error pulses once at the second stop sample; read_data stays 0x11.
- Simultaneous read/deliver: 0x11 held valid; assert read_data_enable exactly in the 0x22 deliver cycle -> valid stays 1, read_data = 0x22, no overrun.
- Reset mid-frame: assert reset during DATA bit 4 of 0xF0 -> all outputs at reset values next cycle; a subsequent 0x0F frame is received intact.
